apb_slave_mem: RTL and testbench



---
 rtl/apb_slave_mem.sv | 147 ++++++++++++++
 tb/tb_apb_slave_mem.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// ============================================================================
// apb_slave_mem : APB completer backed by a word-addressed register memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  RESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int         IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic                    err_q;
    logic [3:0]              wait_cnt;

    logic [IDX_W-1:0]        setup_idx;
    logic                    setup_err;
    logic                    do_setup;
    logic                    do_tick;
    logic                    do_complete;
    logic                    do_abort;

    // Decode of the address presented on a setup edge.
    assign setup_idx = PADDR[IDX_W+1:2];
    assign setup_err = (PADDR[1:0] != 2'b00) ||
                       (32'(PADDR[ADDR_WIDTH-1:2]) >= 32'(DEPTH));

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A setup edge seen in ACCESS restarts the transfer and drops the old one.
    always_comb begin
        state_next  = state;
        do_setup    = 1'b0;
        do_tick     = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    do_setup   = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    do_abort   = 1'b1;
                    state_next = IDLE;
                end else if (!PENABLE) begin
                    do_setup   = 1'b1;
                end else if (PREADY) begin
                    do_complete = 1'b1;
                    state_next  = IDLE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
            PRDATA   <= '0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_setup) begin
                idx_q    <= setup_idx;
                write_q  <= PWRITE;
                err_q    <= setup_err;
                wait_cnt <= WAIT_CNT_INIT;
                if (WAIT_STATES == 0) begin
                    PREADY  <= 1'b1;
                    PSLVERR <= setup_err;
                    PRDATA  <= (!PWRITE && !setup_err) ? mem[setup_idx] : '0;
                end else begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
            end else if (do_tick) begin
                wait_cnt <= wait_cnt - 4'd1;
                // Response is registered on the edge the counter reaches zero.
                if (wait_cnt == 4'd1) begin
                    PREADY  <= 1'b1;
                    PSLVERR <= err_q;
                    PRDATA  <= (!write_q && !err_q) ? mem[idx_q] : '0;
                end
            end else if (do_complete) begin
                if (write_q && !err_q) begin
                    mem[idx_q] <= PWDATA;
                end
                wait_cnt <= 4'd0;
                PREADY   <= 1'b0;
                PSLVERR  <= 1'b0;
                PRDATA   <= '0;
            end else if (do_abort) begin
                wait_cnt <= 4'd0;
                PREADY   <= 1'b0;
                PSLVERR  <= 1'b0;
                PRDATA   <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// tb_apb_slave_mem : directed bench for apb_slave_mem (WAIT_STATES 1 and 0)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  psel = 2'b00;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h00;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .RESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(1)) dut1 (
        .PCLK(clk), .RESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
    );

    typedef struct {
        bit          dut;
        bit          wr;
        logic [7:0]  addr;
        logic [7:0]  acc_addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a falling edge; leaves the bus idle one cycle after completion,
    // so consecutive calls issue back-to-back transfers.
    task automatic xfer(input bit which, input bit wr, input logic [7:0] addr,
                        input logic [7:0] acc_addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
        int k;
        psel    = which ? 2'b10 : 2'b01;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(negedge clk);
        penable = 1'b1;
        paddr   = acc_addr;
        k = 0;
        while (!(which ? pready1 : pready0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), which ? 32'd1 : 32'd0);
        rdata = which ? prdata1 : prdata0;
        err   = which ? pslverr1 : pslverr0;
        @(negedge clk);
        chk("pready_one_cycle", {31'b0, (which ? pready1 : pready0)}, 32'd0);
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        //          dut  wr   addr   acc    wdata          exp_rdata      err
        vecs.push_back('{1'b1, 1'b1, 8'h04, 8'h04, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h04, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 32'h11111111, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8'h7C, 8'h7C, 32'hA5A50F0F, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 32'h0,        32'h11111111, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8'h7C, 8'h7C, 32'h0,        32'hA5A50F0F, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h80, 8'h80, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 8'h02, 8'h02, 32'hFFFFFFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 8'h08, 8'h08, 32'hCAFEF00D, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'h08, 8'h08, 32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'hFF, 32'h0,        32'h00000000, 1'b1});

        repeat (2) @(negedge clk);
        chk("rst_pready0",  {31'b0, pready0},  32'd0);
        chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
        chk("rst_prdata0",  prdata0,           32'd0);
        chk("rst_pready1",  {31'b0, pready1},  32'd0);
        chk("rst_pslverr1", {31'b0, pslverr1}, 32'd0);
        chk("rst_prdata1",  prdata1,           32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].acc_addr, vecs[i].wdata, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Access phase without a setup phase is ignored.
        psel = 2'b10; penable = 1'b1; pwrite = 1'b0; paddr = 8'h04;
        repeat (3) begin
            @(negedge clk);
            chk("no_setup_pready", {31'b0, pready1}, 32'd0);
        end
        psel = 2'b00; penable = 1'b0;
        @(negedge clk);

        // PSEL dropped in the access phase of a write: no response, no write.
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h12345678;
        @(negedge clk);
        psel = 2'b00; penable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("abort_pready", {31'b0, pready1}, 32'd0);
        end
        penable = 1'b0;
        xfer(1'b1, 1'b0, 8'h08, 8'h08, 32'h0, rd, er);
        chk("abort_mem", rd, 32'hCAFEF00D);

        // Asynchronous reset while a response is being presented.
        psel = 2'b01; penable = 1'b0; pwrite = 1'b0; paddr = 8'h7C;
        @(negedge clk);
        penable = 1'b1;
        chk("ws0_pready_before_rst", {31'b0, pready0}, 32'd1);
        chk("ws0_prdata_before_rst", prdata0, 32'hA5A50F0F);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pready", {31'b0, pready0}, 32'd0);
        chk("async_rst_prdata", prdata0, 32'd0);
        psel = 2'b00; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset pulse during the wait state of a write.
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h55AA55AA;
        @(negedge clk);
        penable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait_pready", {31'b0, pready1}, 32'd0);
        psel = 2'b00; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b1, 1'b0, 8'h10, 8'h10, 32'h0, rd, er);
        chk("rst_no_commit", rd, 32'd0);
        xfer(1'b1, 1'b0, 8'h04, 8'h04, 32'h0, rd, er);
        chk("rst_mem_cleared", rd, 32'd0);

        // Restart: a new setup during the access phase drops the pending write.
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h77777777;
        @(negedge clk);
        xfer(1'b1, 1'b0, 8'h0C, 8'h0C, 32'h0, rd, er);
        chk("restart_rdata", rd, 32'd0);
        xfer(1'b1, 1'b0, 8'h0C, 8'h0C, 32'h0, rd, er);
        chk("restart_no_write", rd, 32'd0);

        // PADDR changes during the access phase are ignored.
        xfer(1'b1, 1'b1, 8'h04, 8'h04, 32'h0BADF00D, rd, er);
        xfer(1'b1, 1'b1, 8'h08, 8'h08, 32'h600DCAFE, rd, er);
        xfer(1'b1, 1'b0, 8'h04, 8'h08, 32'h0, rd, er);
        chk("paddr_latched", rd, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
